// File: rtl/sprite_pkg.sv
// Shared types and default sheet geometry for the sprite animation blocks.
package sprite_pkg;

  typedef enum logic [1:0] {
    LOOP     = 2'd0,
    PINGPONG = 2'd1,
    ONESHOT  = 2'd2
  } anim_mode_t;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RUN_FWD = 2'd1,
    RUN_REV = 2'd2
  } anim_state_t;

  localparam int DEF_FRAME_W    = 64;
  localparam int DEF_FRAME_H    = 64;
  localparam int DEF_SHEET_COLS = 4;

  // Encoding 3 is reserved and behaves as LOOP.
  function automatic anim_mode_t decode_mode(input logic [1:0] m);
    return (m == 2'd3) ? LOOP : anim_mode_t'(m);
  endfunction

endpackage

// File: rtl/sprite_frame_origin.sv
// Combinational frame index -> sheet pixel origin (column, row) for a
// power-of-two-wide sprite sheet.
module sprite_frame_origin #(
  parameter int N          = 11,
  parameter int IW         = 4,
  parameter int FRAME_W    = 64,
  parameter int FRAME_H    = 64,
  parameter int SHEET_COLS = 4,
  parameter int NUM_FRAMES = 16
) (
  input  logic [IW-1:0] idx,
  output logic [N-1:0]  col,
  output logic [N-1:0]  row
);

  localparam int     CB      = $clog2(SHEET_COLS);
  localparam longint MAX_COL = longint'(SHEET_COLS - 1) * FRAME_W;
  localparam longint MAX_ROW = longint'((NUM_FRAMES - 1) / SHEET_COLS) * FRAME_H;
  localparam longint LIMIT   = longint'(1) << N;

  if ((SHEET_COLS < 1) || ((SHEET_COLS & (SHEET_COLS - 1)) != 0)) begin : g_cols_pow2
    $error("sprite_frame_origin: SHEET_COLS must be a power of two");
  end
  if ((MAX_COL >= LIMIT) || (MAX_ROW >= LIMIT)) begin : g_origin_fits
    $error("sprite_frame_origin: frame origin does not fit in N bits");
  end

  logic [N-1:0] idx_n;

  assign idx_n = N'(idx);
  // Low index bits pick the column, the remaining bits pick the row.
  assign col   = (idx_n & N'(SHEET_COLS - 1)) * N'(FRAME_W);
  assign row   = (idx_n >> CB) * N'(FRAME_H);

endmodule

// File: rtl/sprite_anim_seq.sv
// Sprite-sheet animation sequencer: steps a frame index through a programmed
// range every (hold+1) video frames and registers the matching sheet origin.
module sprite_anim_seq
  import sprite_pkg::*;
#(
  parameter int N          = 11,
  parameter int FRAME_W    = DEF_FRAME_W,
  parameter int FRAME_H    = DEF_FRAME_H,
  parameter int SHEET_COLS = DEF_SHEET_COLS,
  parameter int NUM_FRAMES = 16,
  parameter int HOLD_W     = 8,
  localparam int IW        = $clog2(NUM_FRAMES)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              frame_tick,
  input  logic              start,
  input  logic              stop,
  input  logic [1:0]        mode,
  input  logic [IW-1:0]     first_frame,
  input  logic [IW-1:0]     last_frame,
  input  logic [HOLD_W-1:0] hold,
  output logic [IW-1:0]     frameIdx,
  output logic [N-1:0]      stateCol,
  output logic [N-1:0]      stateRow,
  output logic              busy,
  output logic              done
);

  localparam logic [IW-1:0] MAXF   = IW'(NUM_FRAMES - 1);
  localparam logic [IW:0]   MAXF_X = {1'b0, MAXF};

  function automatic logic [IW-1:0] clamp_frame(input logic [IW-1:0] f);
    if ({1'b0, f} > MAXF_X) return MAXF;
    return f;
  endfunction

  anim_state_t       state, state_d;
  anim_mode_t        mode_q;
  logic [IW-1:0]     first_q, last_q;
  logic [HOLD_W-1:0] hold_q;
  logic [HOLD_W-1:0] hold_cnt, hold_cnt_d;
  logic [IW-1:0]     idx_d;
  logic              done_d;
  logic              load;
  logic              degen;
  logic [N-1:0]      col_d, row_d;

  assign degen = (first_q >= last_q);
  assign busy  = (state != IDLE);

  always_comb begin
    state_d    = state;
    idx_d      = frameIdx;
    hold_cnt_d = hold_cnt;
    done_d     = 1'b0;
    load       = 1'b0;
    if (stop) begin
      state_d = IDLE;
    end else if (start) begin
      load       = 1'b1;
      idx_d      = clamp_frame(first_frame);
      hold_cnt_d = '0;
      state_d    = RUN_FWD;
    end else if ((state != IDLE) && frame_tick) begin
      if (hold_cnt != hold_q) begin
        hold_cnt_d = hold_cnt + HOLD_W'(1);
      end else begin
        hold_cnt_d = '0;
        unique case (mode_q)
          ONESHOT: begin
            // A degenerate range finishes on its first advance without moving.
            if (degen || ((frameIdx + IW'(1)) == last_q)) begin
              state_d = IDLE;
              done_d  = 1'b1;
            end
            if (!degen) idx_d = frameIdx + IW'(1);
          end
          PINGPONG: begin
            if (!degen) begin
              if (state == RUN_FWD) begin
                if (frameIdx == last_q) begin
                  idx_d   = last_q - IW'(1);
                  state_d = RUN_REV;
                end else begin
                  idx_d = frameIdx + IW'(1);
                end
              end else begin
                if (frameIdx == first_q) begin
                  idx_d   = first_q + IW'(1);
                  state_d = RUN_FWD;
                end else begin
                  idx_d = frameIdx - IW'(1);
                end
              end
            end
          end
          default: begin
            if (!degen) idx_d = (frameIdx == last_q) ? first_q : frameIdx + IW'(1);
          end
        endcase
      end
    end
  end

  sprite_frame_origin #(
    .N          (N),
    .IW         (IW),
    .FRAME_W    (FRAME_W),
    .FRAME_H    (FRAME_H),
    .SHEET_COLS (SHEET_COLS),
    .NUM_FRAMES (NUM_FRAMES)
  ) u_origin (
    .idx (idx_d),
    .col (col_d),
    .row (row_d)
  );

  // Index and origin are registered on the same edge so they never skew.
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      frameIdx <= '0;
      stateCol <= '0;
      stateRow <= '0;
      hold_cnt <= '0;
      done     <= 1'b0;
    end else begin
      state    <= state_d;
      frameIdx <= idx_d;
      stateCol <= col_d;
      stateRow <= row_d;
      hold_cnt <= hold_cnt_d;
      done     <= done_d;
    end
  end

  always_ff @(posedge clk) begin
    if (load) begin
      mode_q  <= decode_mode(mode);
      first_q <= clamp_frame(first_frame);
      last_q  <= clamp_frame(last_frame);
      hold_q  <= hold;
    end
  end

endmodule
